// File: rtl/reset_req_pkg.sv
// -----------------------------------------------------------------------------
// reset_req_pkg
// Shared definitions for the partial-reset request scheduler.
//   state_e        : scheduler FSM encoding (reported on the STATE debug port)
//   CH_*           : fixed subsystem-to-channel mapping
//   DEF_*          : default parameter values
// -----------------------------------------------------------------------------
package reset_req_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PULSE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RETRY = 3'd3
  } state_e;

  localparam int CH_ADC  = 0;
  localparam int CH_TRG  = 1;
  localparam int CH_DSR  = 2;
  localparam int CH_MMCM = 3;

  localparam int DEF_NREQ      = 4;
  localparam int DEF_PULSE_LEN = 16;
  localparam int DEF_TMO       = 4000;
  localparam int DEF_MAX_RETRY = 3;

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick among pending channels. The search starts at
// the channel after the last granted one and wraps around.
//   pend_i     : pending request bits
//   last_i     : index of the most recently granted channel
//   win_o      : one-hot winner (zero when nothing is pending)
//   win_idx_o  : index of the winner (last_i when nothing is pending)
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int LW   = 2
) (
  input  logic [NREQ-1:0] pend_i,
  input  logic [LW-1:0]   last_i,
  output logic [NREQ-1:0] win_o,
  output logic [LW-1:0]   win_idx_o
);

  always_comb begin
    logic [LW:0] c;
    logic        found;
    win_o     = '0;
    win_idx_o = last_i;
    found     = 1'b0;
    c         = '0;
    for (int i = 1; i <= NREQ; i++) begin
      // one spare bit holds last+i before the wrap back into range
      c = {1'b0, last_i} + (LW+1)'(i);
      if (c >= (LW+1)'(NREQ)) c = c - (LW+1)'(NREQ);
      if (!found && pend_i[c[LW-1:0]]) begin
        found               = 1'b1;
        win_o[c[LW-1:0]]    = 1'b1;
        win_idx_o           = c[LW-1:0];
      end
    end
  end

endmodule

// File: rtl/reset_req_scheduler.sv
// -----------------------------------------------------------------------------
// reset_req_scheduler
// Sequences subsystem (partial) resets after power-on. Rising edges on REQ
// queue one reset per channel; channels are served round-robin, one reset
// pulse at a time, followed by a wait for the subsystem's RDY. A timeout
// re-pulses up to MAX_RETRY times before the channel is flagged as failed.
//   CLK      : 40 MHz system clock
//   RST      : synchronous active-high reset (SYS_RST)
//   REQ      : level requests, a rising edge queues one reset
//   RDY      : per-subsystem ready / lock
//   SUB_RST  : subsystem reset lines, at most one high
//   GNT      : one-hot channel in service
//   ACK      : one-cycle pulse on successful completion
//   FAIL     : sticky, set when retries are exhausted, cleared on a later ACK
//   BUSY     : scheduler not idle
//   STATE    : FSM encoding for debug status
// -----------------------------------------------------------------------------
module reset_req_scheduler
  import reset_req_pkg::*;
#(
  parameter int NREQ      = DEF_NREQ,
  parameter int PULSE_LEN = DEF_PULSE_LEN,
  parameter int TMO       = DEF_TMO,
  parameter int MAX_RETRY = DEF_MAX_RETRY
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [NREQ-1:0] REQ,
  input  logic [NREQ-1:0] RDY,
  output logic [NREQ-1:0] SUB_RST,
  output logic [NREQ-1:0] GNT,
  output logic [NREQ-1:0] ACK,
  output logic [NREQ-1:0] FAIL,
  output logic            BUSY,
  output logic [2:0]      STATE
);

  localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int PW = $clog2(PULSE_LEN + 1);
  localparam int TW = $clog2(TMO + 1);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  state_e          state_q, state_d;
  logic [NREQ-1:0] req_q, pend_q, pend_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [NREQ-1:0] fail_q, fail_d;
  logic [LW-1:0]   last_q, last_d;
  logic [PW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic [NREQ-1:0] clr;
  logic [NREQ-1:0] win;
  logic [LW-1:0]   win_idx;

  rr_arbiter #(
    .NREQ (NREQ),
    .LW   (LW)
  ) u_arb (
    .pend_i    (pend_q),
    .last_i    (last_q),
    .win_o     (win),
    .win_idx_o (win_idx)
  );

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      pend_q  <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      fail_q  <= '0;
      last_q  <= LW'(NREQ - 1);
      cnt_q   <= '0;
      tmr_q   <= '0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= REQ;
      pend_q  <= pend_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      fail_q  <= fail_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      retry_q <= retry_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ack_d   = '0;
    fail_d  = fail_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    retry_d = retry_q;
    clr     = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (|pend_q) begin
          state_d = ST_PULSE;
          gnt_d   = win;
          last_d  = win_idx;
          clr     = win;
          retry_d = '0;
          cnt_d   = PW'(PULSE_LEN);
        end
      end
      ST_PULSE: begin
        if (cnt_q == PW'(1)) begin
          state_d = ST_WAIT;
          tmr_d   = '0;
        end else begin
          cnt_d = cnt_q - PW'(1);
        end
      end
      ST_WAIT: begin
        // ready wins over a timeout landing in the same cycle
        if (|(RDY & gnt_q)) begin
          state_d = ST_IDLE;
          ack_d   = gnt_q;
          fail_d  = fail_q & ~gnt_q;
          gnt_d   = '0;
        end else if (tmr_q == TW'(TMO - 1)) begin
          state_d = ST_RETRY;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      ST_RETRY: begin
        if (retry_q < RW'(MAX_RETRY)) begin
          state_d = ST_PULSE;
          retry_d = retry_q + RW'(1);
          cnt_d   = PW'(PULSE_LEN);
        end else begin
          state_d = ST_IDLE;
          fail_d  = fail_q | gnt_q;
          gnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // an edge on the channel in service re-queues it for a later sequence
    pend_d = (pend_q | (REQ & ~req_q)) & ~clr;
  end

  // Outputs
  always_comb begin
    SUB_RST = (state_q == ST_PULSE) ? gnt_q : '0;
    GNT     = gnt_q;
    ACK     = ack_q;
    FAIL    = fail_q;
    BUSY    = (state_q != ST_IDLE);
    STATE   = state_q;
  end

endmodule
